// File: rtl/amo_sequencer.sv
// RV32A sequencer for LR.W, SC.W and AMO read-modify-write. It owns the data-memory port and the LR/SC reservation.
// Define AMO_MINMAX_EN to support AMOMIN/AMOMAX/AMOMINU/AMOMAXU. Without it, those codes raise an exception.
module amo_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4:0]            func5,
    input  logic [DATA_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] rs2Data,
    input  logic [DATA_WIDTH-1:0] memReadData,
    input  logic                  memReady,
    input  logic                  snoopWrite,
    input  logic [DATA_WIDTH-1:0] snoopAddress,
    output logic                  memRead,
    output logic                  memWrite,
    output logic [DATA_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic                  stall,
    output logic                  done,
    output logic                  rdWrite,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic                  exception
);
    localparam int WORD_BITS = DATA_WIDTH - 2;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SWAP = 5'b00001;
    localparam logic [4:0] OP_LR   = 5'b00010;
    localparam logic [4:0] OP_SC   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01100;
`ifdef AMO_MINMAX_EN
    localparam logic [4:0] OP_MIN  = 5'b10000;
    localparam logic [4:0] OP_MAX  = 5'b10100;
    localparam logic [4:0] OP_MINU = 5'b11000;
    localparam logic [4:0] OP_MAXU = 5'b11100;
`endif

    typedef enum logic [2:0] {IDLE, READ, MODIFY, WRITE, DONE} stateT;

    stateT                 state, nextState;
    logic [4:0]            opReg;
    logic [WORD_BITS-1:0]  wordReg;
    logic [DATA_WIDTH-1:0] rs2Reg, resultReg, newReg;
    logic                  excReg;
    logic                  resValid;
    logic [WORD_BITS-1:0]  resWord;

    function automatic logic isSupported(input logic [4:0] op);
        case (op)
            OP_LR, OP_SC, OP_SWAP, OP_ADD, OP_XOR, OP_AND, OP_OR: isSupported = 1'b1;
`ifdef AMO_MINMAX_EN
            OP_MIN, OP_MAX, OP_MINU, OP_MAXU:                     isSupported = 1'b1;
`endif
            default:                                              isSupported = 1'b0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] amoCompute(input logic [4:0] op,
                                                         input logic [DATA_WIDTH-1:0] a,
                                                         input logic [DATA_WIDTH-1:0] b);
        case (op)
            OP_ADD:  amoCompute = a + b;
            OP_XOR:  amoCompute = a ^ b;
            OP_AND:  amoCompute = a & b;
            OP_OR:   amoCompute = a | b;
`ifdef AMO_MINMAX_EN
            OP_MIN:  amoCompute = ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:  amoCompute = ($signed(a) < $signed(b)) ? b : a;
            OP_MINU: amoCompute = (a < b) ? a : b;
            OP_MAXU: amoCompute = (a < b) ? b : a;
`endif
            default: amoCompute = b;
        endcase
    endfunction

    logic [WORD_BITS-1:0] reqWord, snoopWord;
    logic                 badOp, isSc, scSuccess;
    logic                 unusedSnoopBits;

    assign reqWord   = address[DATA_WIDTH-1:2];
    assign snoopWord = snoopAddress[DATA_WIDTH-1:2];
    assign badOp     = (address[1:0] != 2'b00) || !isSupported(func5);
    assign isSc      = (func5 == OP_SC);
    // A store to the SC word in the same cycle defeats the SC, even if the reservation still looks valid.
    assign scSuccess = resValid && (resWord == reqWord) && !(snoopWrite && (snoopWord == reqWord));
    assign unusedSnoopBits = &{1'b0, snoopAddress[1:0]};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        nextState    = state;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        memAddress   = '0;
        memWriteData = '0;
        stall        = 1'b0;
        done         = 1'b0;
        rdWrite      = 1'b0;
        rdData       = '0;
        exception    = 1'b0;
        case (state)
            IDLE: begin
                stall = start;
                if (start) begin
                    if (badOp)     nextState = DONE;
                    else if (isSc) nextState = scSuccess ? WRITE : DONE;
                    else           nextState = READ;
                end
            end
            READ: begin
                stall      = 1'b1;
                memRead    = 1'b1;
                memAddress = {wordReg, 2'b00};
                if (memReady) nextState = (opReg == OP_LR) ? DONE : MODIFY;
            end
            MODIFY: begin
                stall     = 1'b1;
                nextState = WRITE;
            end
            WRITE: begin
                stall        = 1'b1;
                memWrite     = 1'b1;
                memAddress   = {wordReg, 2'b00};
                memWriteData = newReg;
                if (memReady) nextState = DONE;
            end
            DONE: begin
                done      = 1'b1;
                rdWrite   = !excReg;
                rdData    = resultReg;
                exception = excReg;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opReg     <= '0;
            wordReg   <= '0;
            rs2Reg    <= '0;
            resultReg <= '0;
            newReg    <= '0;
            excReg    <= 1'b0;
            resValid  <= 1'b0;
            resWord   <= '0;
        end else begin
            if (snoopWrite && (snoopWord == resWord)) resValid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    opReg     <= func5;
                    wordReg   <= reqWord;
                    rs2Reg    <= rs2Data;
                    newReg    <= rs2Data;
                    excReg    <= badOp;
                    resultReg <= '0;
                    if (isSc) begin
                        resValid  <= 1'b0;
                        resultReg <= (!badOp && scSuccess) ? '0 : DATA_WIDTH'(1);
                    end
                end
                READ: if (memReady) begin
                    resultReg <= memReadData;
                    // The LR reservation is not set if a store hits the same word while the load completes.
                    if (opReg == OP_LR && !(snoopWrite && (snoopWord == wordReg))) begin
                        resValid <= 1'b1;
                        resWord  <= wordReg;
                    end
                end
                MODIFY: newReg <= amoCompute(opReg, resultReg, rs2Reg);
                WRITE:  if (memReady && (wordReg == resWord)) resValid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_amo_sequencer.sv
// Self-checking bench for amo_sequencer: directed scenarios followed by randomized ops.
// A transaction-level model supplies memory contents, the reservation and the expected cycle timeline.
module tb_amo_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, memReady, snoopWrite;
    logic [4:0]  func5;
    logic [31:0] address, rs2Data, memReadData, snoopAddress;
    logic        memRead, memWrite, stall, done, rdWrite, exception;
    logic [31:0] memAddress, memWriteData, rdData;

    always #5 clk = ~clk;

    amo_sequencer #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .func5(func5), .address(address),
        .rs2Data(rs2Data), .memReadData(memReadData), .memReady(memReady),
        .snoopWrite(snoopWrite), .snoopAddress(snoopAddress), .memRead(memRead),
        .memWrite(memWrite), .memAddress(memAddress), .memWriteData(memWriteData),
        .stall(stall), .done(done), .rdWrite(rdWrite), .rdData(rdData), .exception(exception)
    );

    localparam logic [4:0] F_ADD = 5'b00000, F_SWAP = 5'b00001, F_LR = 5'b00010, F_SC = 5'b00011;
    localparam logic [4:0] F_XOR = 5'b00100, F_OR = 5'b01000, F_AND = 5'b01100;
    localparam logic [4:0] F_MIN = 5'b10000, F_MAX = 5'b10100, F_MINU = 5'b11000, F_MAXU = 5'b11100;
`ifdef AMO_MINMAX_EN
    localparam bit MINMAX = 1'b1;
`else
    localparam bit MINMAX = 1'b0;
`endif

    int checks = 0, errors = 0, opNum = 0, cycNum = 0;
    logic [31:0] memArr [logic [29:0]];
    bit          resValid = 1'b0;
    logic [29:0] resWord = '0;
    logic [4:0]  fList [12] = '{F_LR, F_SC, F_SC, F_SWAP, F_ADD, F_XOR, F_AND, F_OR,
                                F_MIN, F_MAX, F_MINU, F_MAXU};

    function automatic logic [31:0] memGet(input logic [29:0] w);
        if (memArr.exists(w)) return memArr[w];
        return 32'h0;
    endfunction

    function automatic bit isRmw(input logic [4:0] f);
        case (f)
            F_SWAP, F_ADD, F_XOR, F_AND, F_OR: return 1'b1;
            F_MIN, F_MAX, F_MINU, F_MAXU:      return MINMAX;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] amoCalc(input logic [4:0] f, input logic [31:0] old, input logic [31:0] b);
        case (f)
            F_SWAP:  return b;
            F_ADD:   return old + b;
            F_XOR:   return old ^ b;
            F_AND:   return old & b;
            F_OR:    return old | b;
            F_MIN:   return ($signed(old) <= $signed(b)) ? old : b;
            F_MAX:   return ($signed(old) >= $signed(b)) ? old : b;
            F_MINU:  return (old <= b) ? old : b;
            F_MAXU:  return (old >= b) ? old : b;
            default: return old;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL op%0d cyc%0d %s: got %h expected %h", opNum, cycNum, tag, obs, exp);
        end
    endtask

    task automatic pickSnoop(output bit s, output logic [31:0] a, input logic [29:0] w);
        s = ($urandom % 4) == 0;
        case ($urandom % 3)
            0:       a = {resWord, 2'($urandom)};
            1:       a = {w, 2'($urandom)};
            default: a = 32'h1000 + ($urandom % 8) * 4 + ($urandom % 4);
        endcase
    endtask

    task automatic idleCycle(input bit s, input logic [31:0] a);
        @(negedge clk);
        start = 1'b0; snoopWrite = s; snoopAddress = a; memReady = 1'($urandom);
        #1;
        check("idle stall", 32'(stall), 32'(0));
        check("idle done", 32'(done), 32'(0));
        check("idle memRead", 32'(memRead), 32'(0));
        check("idle memWrite", 32'(memWrite), 32'(0));
        if (s && a[31:2] == resWord) resValid = 1'b0;
    endtask

    // One instruction from start to done. dR/dW are memReady stall cycles for the read and write phases.
    task automatic runOp(input logic [4:0] f5, input logic [31:0] addr, input logic [31:0] rs2,
                         input int dR, input int dW, input bit rndSnoop, input bit holdStart);
        logic [29:0] w;
        bit          isLr, isSc, exc, snp, expRd, expWr;
        logic [31:0] snpA, expRes, newVal;
        int          rdS, rdE, wrS, wrE, doneC;
        w = addr[31:2];
        isLr = (f5 == F_LR);
        isSc = (f5 == F_SC);
        exc = (addr[1:0] != 2'b00) || !(isLr || isSc || isRmw(f5));
        rdS = -1; rdE = -1; wrS = -1; wrE = -1; doneC = 1;
        expRes = 0; newVal = 0;
        opNum++;
        for (int c = 0; c <= doneC; c++) begin
            cycNum = c;
            @(negedge clk);
            snp = 1'b0; snpA = 32'h0;
            if (rndSnoop) pickSnoop(snp, snpA, w);
            if (c == 0) begin
                start = 1'b1; func5 = f5; address = addr; rs2Data = rs2;
                if (exc) doneC = 1;
                else if (isSc) begin
                    if (resValid && resWord == w && !(snp && snpA[31:2] == w)) begin
                        wrS = 1; wrE = 1 + dW; doneC = wrE + 1; expRes = 0; newVal = rs2;
                    end else begin
                        doneC = 1; expRes = 1;
                    end
                end else begin
                    rdS = 1; rdE = 1 + dR; expRes = memGet(w);
                    if (isLr) doneC = rdE + 1;
                    else begin
                        newVal = amoCalc(f5, expRes, rs2);
                        wrS = rdE + 2; wrE = wrS + dW; doneC = wrE + 1;
                    end
                end
            end else begin
                start = holdStart; func5 = 5'($urandom); address = $urandom; rs2Data = $urandom;
            end
            snoopWrite = snp; snoopAddress = snpA;
            expRd = (rdS >= 0) && (c >= rdS) && (c <= rdE);
            expWr = (wrS >= 0) && (c >= wrS) && (c <= wrE);
            memReady = expRd ? (c == rdE) : expWr ? (c == wrE) : 1'($urandom);
            memReadData = expRd ? memGet(w) : $urandom;
            #1;
            check("memRead", 32'(memRead), 32'(expRd));
            check("memWrite", 32'(memWrite), 32'(expWr));
            check("memAddress", memAddress, (expRd || expWr) ? {w, 2'b00} : 32'h0);
            if (expWr) check("memWriteData", memWriteData, newVal);
            check("done", 32'(done), 32'(c == doneC));
            check("stall", 32'(stall), 32'(c != doneC));
            if (c == doneC) begin
                check("rdWrite", 32'(rdWrite), 32'(!exc));
                check("exception", 32'(exception), 32'(exc));
                if (!exc) check("rdData", rdData, expRes);
            end
            if (snp && snpA[31:2] == resWord) resValid = 1'b0;
            if (isLr && !exc && c == rdE && !(snp && snpA[31:2] == w)) begin
                resValid = 1'b1; resWord = w;
            end
            if (isSc && c == 0) resValid = 1'b0;
            if (!isSc && c == wrE && resWord == w) resValid = 1'b0;
            if (c == wrE) memArr[w] = newVal;
        end
    endtask

    initial begin
        bit          lastLr, s;
        logic [31:0] lastAddr, a, addr;
        logic [4:0]  f5;
        int          r;
        reset = 1'b1; start = 1'b0; func5 = '0; address = '0; rs2Data = '0;
        memReadData = '0; memReady = 1'b0; snoopWrite = 1'b0; snoopAddress = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst memRead", 32'(memRead), 32'(0));
        check("rst memWrite", 32'(memWrite), 32'(0));
        check("rst memAddress", memAddress, 32'h0);
        check("rst memWriteData", memWriteData, 32'h0);
        check("rst stall", 32'(stall), 32'(0));
        check("rst done", 32'(done), 32'(0));
        check("rst rdWrite", 32'(rdWrite), 32'(0));
        check("rst rdData", rdData, 32'h0);
        check("rst exception", 32'(exception), 32'(0));
        reset = 1'b0;

        memArr[32'h100 >> 2] = 32'h1234;
        runOp(F_LR, 32'h100, 32'h0, 0, 0, 0, 0);
        runOp(F_SC, 32'h100, 32'hAA, 0, 0, 0, 0);
        runOp(F_SC, 32'h100, 32'hBB, 0, 0, 0, 0);
        runOp(F_LR, 32'h100, 32'h0, 0, 0, 0, 0);
        idleCycle(1'b1, 32'h102);
        runOp(F_SC, 32'h100, 32'hCC, 0, 0, 0, 0);

        memArr[32'h200 >> 2] = 32'hFFFF_FFFF;
        runOp(F_ADD, 32'h200, 32'h2, 0, 0, 0, 0);
        runOp(F_ADD, 32'h200, 32'h7, 3, 0, 0, 0);
        memArr[32'h300 >> 2] = 32'h8000_0000;
        runOp(F_MIN, 32'h300, 32'h5, 0, 0, 0, 0);
        memArr[32'h300 >> 2] = 32'h8000_0000;
        runOp(F_MINU, 32'h300, 32'h5, 0, 0, 0, 0);
        runOp(F_SWAP, 32'h201, 32'h9, 0, 0, 0, 0);
        runOp(5'b11111, 32'h200, 32'h9, 0, 0, 0, 0);

        // Reset while WRITE is pending must abort the op and drop the reservation.
        runOp(F_LR, 32'h100, 32'h0, 0, 0, 0, 0);
        opNum++; cycNum = 0;
        @(negedge clk);
        start = 1'b1; func5 = F_SWAP; address = 32'h200; rs2Data = 32'h55;
        memReady = 1'b1; memReadData = memGet(30'(32'h200 >> 2));
        @(negedge clk);
        start = 1'b0; cycNum = 1;
        #1 check("rst-seq memRead", 32'(memRead), 32'(1));
        @(negedge clk);
        cycNum = 2;
        @(negedge clk);
        cycNum = 3; memReady = 1'b0;
        #1 check("rst-seq memWrite", 32'(memWrite), 32'(1));
        check("rst-seq memWriteData", memWriteData, 32'h55);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; cycNum = 4;
        #1 check("rst-seq memWrite drop", 32'(memWrite), 32'(0));
        check("rst-seq done", 32'(done), 32'(0));
        check("rst-seq stall", 32'(stall), 32'(0));
        check("rst-seq memRead", 32'(memRead), 32'(0));
        resValid = 1'b0;
        runOp(F_SC, 32'h100, 32'hDD, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) memArr[30'((32'h1000 >> 2) + i)] = $urandom;
        memArr[32'h1004 >> 2] = 32'h8000_0000;
        lastLr = 1'b0; lastAddr = 32'h1000;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom % 14);
            f5 = (r < 12) ? fList[r] : 5'($urandom);
            if (lastLr && ($urandom % 2) == 1) begin
                f5 = F_SC; addr = lastAddr;
            end else begin
                addr = 32'h1000 + ($urandom % 8) * 4 + ((($urandom % 8) == 0) ? ($urandom % 4) : 0);
            end
            runOp(f5, addr, $urandom, int'($urandom % 3), int'($urandom % 3), 1'b1, 1'($urandom));
            lastLr = (f5 == F_LR); lastAddr = addr;
            if (($urandom % 4) == 0) begin
                pickSnoop(s, a, addr[31:2]);
                idleCycle(s, a);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
